// File: rtl/mw_seq_adder_pkg.sv
// Shared types and helpers for the sequential multi-word adder and its
// carry-skip chunk adder.
package mw_seq_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Carry-skip block size inside cs_adder.
  localparam int CS_BLK = 4;

  // Chunk counter width: max(1, clog2(words)).
  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mw_seq_adder_cs_adder.sv
// WIDTH-bit carry-skip adder: ripple inside CS_BLK-bit blocks, block carry
// bypasses the ripple when every bit of the block propagates.
module cs_adder
  import mw_seq_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] Number1_i,
  input  logic [WIDTH-1:0] Number2_i,
  input  logic             Carry_i,
  output logic [WIDTH-1:0] Result_o,
  output logic             Carry_o
);

  localparam int NBLK = (WIDTH + CS_BLK - 1) / CS_BLK;
  localparam int PW   = NBLK * CS_BLK;
  localparam int LBLK = (WIDTH - 1) / CS_BLK;
  localparam int LBIT = (WIDTH - 1) % CS_BLK;

  logic [PW-1:0]                  a_p, b_p, p, g, s_p;
  logic [NBLK:0]                  c_blk;
  logic [NBLK-1:0][CS_BLK:0]      rc;

  // Padding bits are zero, so they never propagate; the real carry-out is
  // taken from the ripple at bit WIDTH-1 (or the skip chain when aligned).
  assign a_p = PW'(Number1_i);
  assign b_p = PW'(Number2_i);
  assign p   = a_p ^ b_p;
  assign g   = a_p & b_p;

  always_comb begin
    c_blk    = '0;
    rc       = '0;
    s_p      = '0;
    c_blk[0] = Carry_i;
    for (int k = 0; k < NBLK; k++) begin
      rc[k][0] = c_blk[k];
      for (int j = 0; j < CS_BLK; j++) begin
        s_p[k*CS_BLK+j] = p[k*CS_BLK+j] ^ rc[k][j];
        rc[k][j+1]      = g[k*CS_BLK+j] | (p[k*CS_BLK+j] & rc[k][j]);
      end
      c_blk[k+1] = (&p[k*CS_BLK +: CS_BLK]) ? c_blk[k] : rc[k][CS_BLK];
    end
  end

  assign Result_o = s_p[WIDTH-1:0];

  generate
    if (LBIT == CS_BLK - 1) begin : g_co_skip
      assign Carry_o = c_blk[LBLK+1];
    end else begin : g_co_rip
      assign Carry_o = rc[LBLK][LBIT+1];
    end
  endgenerate

endmodule

// File: rtl/mw_seq_adder.sv
// Sequential WIDTH*WORDS-bit adder: feeds one chunk per cycle (LSW first)
// through a single cs_adder, chaining the carry through a register.
module mw_seq_adder
  import mw_seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WORDS = 2
) (
  input  logic                   Clk_i,
  input  logic                   Rst_n_i,
  input  logic                   Start_i,
  input  logic [WIDTH*WORDS-1:0] Number1_i,
  input  logic [WIDTH*WORDS-1:0] Number2_i,
  input  logic                   Carry_i,
  output logic                   Busy_o,
  output logic                   Done_o,
  output logic [WIDTH*WORDS-1:0] Result_o,
  output logic                   Carry_o,
  output logic                   Overflow_o
);

  localparam int N  = WIDTH * WORDS;
  localparam int CW = cnt_w(WORDS);

  generate
    if (WORDS < 1) begin : g_bad_words
      $error("mw_seq_adder: WORDS must be >= 1");
    end
  endgenerate

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [N-1:0]                  a_sh, b_sh;
  logic                          carry_r;
  logic                          a_msb, b_msb;
  logic [WORDS-1:0][WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]              sum;
  logic                          c_out;
  logic                          last;

  cs_adder #(.WIDTH(WIDTH)) u_cs (
    .Number1_i (a_sh[WIDTH-1:0]),
    .Number2_i (b_sh[WIDTH-1:0]),
    .Carry_i   (carry_r),
    .Result_o  (sum),
    .Carry_o   (c_out)
  );

  // Accumulator with the in-flight chunk merged, so the completion edge can
  // publish the full sum in the same cycle the last chunk is produced.
  always_comb begin
    acc_nxt = acc;
    for (int w = 0; w < WORDS; w++)
      if (cnt == CW'(w)) acc_nxt[w] = sum;
  end

  assign last = (cnt == CW'(WORDS - 1));

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      carry_r    <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      acc        <= '0;
      Busy_o     <= 1'b0;
      Done_o     <= 1'b0;
      Result_o   <= '0;
      Carry_o    <= 1'b0;
      Overflow_o <= 1'b0;
    end else begin
      Done_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start_i) begin
            a_sh    <= Number1_i;
            b_sh    <= Number2_i;
            carry_r <= Carry_i;
            a_msb   <= Number1_i[N-1];
            b_msb   <= Number2_i[N-1];
            cnt     <= '0;
            Busy_o  <= 1'b1;
            state   <= ST_RUN;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc     <= acc_nxt;
          carry_r <= c_out;
          a_sh    <= a_sh >> WIDTH;
          b_sh    <= b_sh >> WIDTH;
          if (last) begin
            Result_o   <= acc_nxt;
            Carry_o    <= c_out;
            Overflow_o <= (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
            Done_o     <= 1'b1;
            Busy_o     <= 1'b0;
            cnt        <= '0;
            state      <= ST_DONE;
          end else begin
            cnt        <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mw_seq_adder.sv
// Directed bench for mw_seq_adder (WORDS=2 and WORDS=1) with a result scoreboard.
module tb_mw_seq_adder;

  localparam int W  = 32;
  localparam int N  = 64;
  localparam int N1 = 32;

  typedef struct packed {
    logic [N-1:0] res;
    logic         co;
    logic         ovf;
  } exp_t;

  logic          clk, rst_n;
  logic          start, ci, busy, done, co, ovf;
  logic [N-1:0]  a, b, res;
  logic          start1, ci1, busy1, done1, co1, ovf1;
  logic [N1-1:0] a1, b1, res1;

  int            tests, fails;
  exp_t          sb[$];
  exp_t          sb1[$];
  logic [N-1:0]  last_res;

  mw_seq_adder #(.WIDTH(W), .WORDS(2)) dut (
    .Clk_i(clk), .Rst_n_i(rst_n), .Start_i(start), .Number1_i(a), .Number2_i(b),
    .Carry_i(ci), .Busy_o(busy), .Done_o(done), .Result_o(res), .Carry_o(co),
    .Overflow_o(ovf)
  );

  mw_seq_adder #(.WIDTH(W), .WORDS(1)) dut1 (
    .Clk_i(clk), .Rst_n_i(rst_n), .Start_i(start1), .Number1_i(a1), .Number2_i(b1),
    .Carry_i(ci1), .Busy_o(busy1), .Done_o(done1), .Result_o(res1), .Carry_o(co1),
    .Overflow_o(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c, input int nb);
    logic [N:0] full;
    logic [N:0] msk;
    exp_t e;
    msk  = (65'd1 << nb) - 65'd1;
    full = ({1'b0, x} + {1'b0, y} + {{N{1'b0}}, c}) & msk;
    e.res = full[N-1:0];
    e.co  = (({1'b0, x} + {1'b0, y} + {{N{1'b0}}, c}) >> nb) != 0;
    e.ovf = (x[nb-1] == y[nb-1]) && (full[nb-1] != x[nb-1]);
    return e;
  endfunction

  // Drive a request for one cycle; the edge inside tick() is the accept edge.
  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    a = x; b = y; ci = c; start = 1'b1;
    sb.push_back(model(x, y, c, N));
    tick();
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Waits for Done_o; every non-done cycle the previous result must still hold.
  task automatic wait_done(input int lat, input string tag);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (done === 1'b1) seen = 1;
      else chk({tag, "_hold"}, res, last_res);
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, res, e.res);
      chk({tag, "_carry"}, {63'd0, co}, {63'd0, e.co});
      chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
      chk({tag, "_busy_clr"}, {63'd0, busy}, 64'd0);
      last_res = e.res;
    end
  endtask

  task automatic count_no_done(input int n, input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk(tag, 64'(pulses), 64'd0);
  endtask

  initial begin
    exp_t e1;
    int   cyc1;
    tests = 0; fails = 0; last_res = '0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", res, 64'd0);
    chk("rst_carry_ovf", {62'd0, co, ovf}, 64'd0);
    chk("rst_w1_result", {32'd0, res1}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Carry across the word boundary, then full ripple back-to-back from DONE.
    start_op(64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0);
    wait_done(2, "wordcarry");
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_done(2, "ripple");
    tick(); tick();

    // Input changes and a Start pulse during RUN must be ignored.
    start_op(64'h1, 64'h2, 1'b0);
    a = '1; b = '1; ci = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_no_early_done", {63'd0, done}, 64'd0);
    wait_done(1, "ignore");
    // Start held high while in DONE: restart with no idle gap.
    start_op(64'h10, 64'h20, 1'b0);
    wait_done(2, "b2b");
    count_no_done(4, "no_extra_done");

    // A few pseudo-random back-to-back operations.
    for (int i = 0; i < 4; i++) begin
      start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)));
      wait_done(2, "rand");
    end

    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_done(2, "overflow");
    tick();

    // Asynchronous reset in the middle of RUN.
    start_op(64'h5, 64'h6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_carry_ovf", {62'd0, co, ovf}, 64'd0);
    chk("midrst_result", res, 64'd0);
    tick();
    rst_n = 1'b1;
    sb.delete();
    last_res = '0;
    count_no_done(5, "midrst_no_done");
    start_op(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 1'b0);
    wait_done(2, "after_rst");

    // WORDS = 1 instance: single RUN cycle.
    a1 = 32'hFFFF_FFFF; b1 = 32'h0000_0001; ci1 = 1'b1; start1 = 1'b1;
    sb1.push_back(model(64'(a1), 64'(b1), ci1, N1));
    tick();
    start1 = 1'b0;
    cyc1 = 0;
    while (done1 !== 1'b1 && cyc1 < 20) begin
      tick();
      cyc1++;
    end
    chk("w1_latency", 64'(cyc1), 64'd1);
    e1 = sb1.pop_front();
    chk("w1_result", {32'd0, res1}, e1.res);
    chk("w1_carry", {63'd0, co1}, {63'd0, e1.co});
    chk("w1_ovf", {63'd0, ovf1}, {63'd0, e1.ovf});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
